// File: rtl/mem_arbiter_if.sv
// Requester and memory-bus bundle for mem_arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
);
  // Requester side: per-channel request fields packed channel-major.
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH-1:0]    req_wr;
  logic [2*NUM_CH-1:0]  req_len;
  logic [32*NUM_CH-1:0] req_addr;
  logic [32*NUM_CH-1:0] req_wdata;
  logic                 resp_valid;
  logic [CH_W-1:0]      resp_ch;
  logic [31:0]          resp_data;
  logic                 busy;

  // Byte-wide main-memory bus.
  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;
  logic [31:0]          mem_a;
  logic                 mem_wr;
  logic                 io_buffer_full;

  modport slave (
    input  req_valid, req_wr, req_len, req_addr, req_wdata, mem_din, io_buffer_full,
    output resp_valid, resp_ch, resp_data, busy, mem_dout, mem_a, mem_wr
  );

  modport master (
    output req_valid, req_wr, req_len, req_addr, req_wdata, mem_din, io_buffer_full,
    input  resp_valid, resp_ch, resp_data, busy, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter that serialises 1/2/4-byte reads and writes
// into byte beats on the main-memory bus. Writes to the I/O window stall while
// the UART buffer is full; flush aborts speculative reads of masked channels.
module mem_arbiter #(
  parameter int                NUM_CH     = 2,
  parameter int                CH_W       = 1,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = '1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [2:0]        len_q, len_d;        // transfer length in bytes (1, 2 or 4)
  logic              io_q, io_d;          // target lies in the I/O window
  logic [31:0]       wdata_q, wdata_d;    // shifts down one byte per write beat
  logic [2:0]        beat_q, beat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [CH_W-1:0]   resp_ch_q, resp_ch_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              busy_q, busy_d;

  logic [1:0]        ch_len   [NUM_CH];
  logic [31:0]       ch_addr  [NUM_CH];
  logic [31:0]       ch_wdata [NUM_CH];
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] hi_mask;
  logic              grant_found;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_io;
  logic [3:0]        cap_lane;

  function automatic logic [2:0] len_bytes(input logic [1:0] code);
    case (code)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;   // 11 is reserved and behaves as a word
    endcase
  endfunction

  // Unpack channel fields; a read from a flush-masked channel cannot win in a flush cycle.
  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_len[gi]   = bus.req_len[2*gi +: 2];
    assign ch_addr[gi]  = bus.req_addr[32*gi +: 32];
    assign ch_wdata[gi] = bus.req_wdata[32*gi +: 32];
    assign eligible[gi] = bus.req_valid[gi] &&
                          !(flush && FLUSH_MASK[gi] && !bus.req_wr[gi]);
    // Channels at or above the round-robin pointer are scanned first.
    assign hi_mask[gi]  = eligible[gi] && (CH_W'(gi) >= rr_ptr_q);
  end

  // Read byte lane k-1 is captured on beat k.
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign cap_lane[gi] = (beat_q == 3'(gi + 1));
  end

  // Round-robin pick: lowest eligible index at/after rr_ptr, else lowest overall.
  always_comb begin
    grant_found = |eligible;
    grant_ch    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (eligible[c]) grant_ch = CH_W'(c);
    end
    if (|hi_mask) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (hi_mask[c]) grant_ch = CH_W'(c);
      end
    end
    grant_io = (ch_addr[grant_ch][17:16] == 2'b11);
  end

  // State register and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      ch_q         <= '0;
      len_q        <= 3'd1;
      io_q         <= 1'b0;
      wdata_q      <= '0;
      beat_q       <= '0;
      rdata_q      <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ch_q    <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      ch_q         <= ch_d;
      len_q        <= len_d;
      io_q         <= io_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      rdata_q      <= rdata_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_ch_q    <= resp_ch_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and next-output logic; rdy_in low holds everything.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    ch_d         = ch_q;
    len_d        = len_q;
    io_d         = io_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    rdata_d      = rdata_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    resp_valid_d = resp_valid_q;
    resp_ch_d    = resp_ch_q;
    resp_data_d  = resp_data_q;

    if (rdy_in) begin
      mem_wr_d     = 1'b0;
      resp_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            ch_d    = grant_ch;
            rr_ptr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
            len_d   = len_bytes(ch_len[grant_ch]);
            io_d    = grant_io;
            wdata_d = ch_wdata[grant_ch];
            beat_d  = '0;
            rdata_d = '0;
            mem_a_d = ch_addr[grant_ch];
            if (bus.req_wr[grant_ch]) begin
              state_d    = ST_WRITE;
              mem_dout_d = ch_wdata[grant_ch][7:0];
              mem_wr_d   = !(grant_io && bus.io_buffer_full);
            end else begin
              state_d = ST_READ;
            end
          end
        end
        ST_READ: begin
          if (flush && FLUSH_MASK[ch_q]) begin
            state_d = ST_IDLE;
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (cap_lane[b]) rdata_d[8*b +: 8] = bus.mem_din;
            end
            if (beat_q == len_q) begin
              state_d      = ST_DONE;
              resp_valid_d = 1'b1;
              resp_ch_d    = ch_q;
              resp_data_d  = rdata_d;
            end else begin
              beat_d = beat_q + 3'd1;
              if (beat_q + 3'd1 < len_q) mem_a_d = mem_a_q + 32'd1;
            end
          end
        end
        ST_WRITE: begin
          // mem_wr_q high means the current beat is being written this cycle;
          // low means it is parked on a full I/O buffer and is retried.
          if (mem_wr_q) begin
            if (beat_q == len_q - 3'd1) begin
              state_d      = ST_DONE;
              resp_valid_d = 1'b1;
              resp_ch_d    = ch_q;
              resp_data_d  = '0;
            end else begin
              beat_d     = beat_q + 3'd1;
              mem_a_d    = mem_a_q + 32'd1;
              wdata_d    = wdata_q >> 8;
              mem_dout_d = wdata_q[15:8];
              mem_wr_d   = !(io_q && bus.io_buffer_full);
            end
          end else begin
            mem_wr_d = !(io_q && bus.io_buffer_full);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ch    = resp_ch_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = busy_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  // A frozen cycle must never write, even mid-beat, so the strobe is gated by rdy_in.
  assign bus.mem_wr     = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with three channels (ch2 not flush-masked).
module tb_mem_arbiter;
  localparam int         NUM_CH = 3;
  localparam int         CH_W   = 2;
  localparam logic [2:0] FMASK  = 3'b011;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;
  int   n_cmp;
  int   n_err;
  logic [7:0] mem [4096];
  logic [7:0] t3_data [3];

  mem_arbiter_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  mem_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W), .FLUSH_MASK(FMASK)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Byte memory, frozen together with the rest of the system when rdy_in is low.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      bus.mem_din <= mem[bus.mem_a[11:0]];
      if (bus.mem_wr) mem[bus.mem_a[11:0]] <= bus.mem_dout;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic wr, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wd);
    bus.req_wr[c]             = wr;
    bus.req_len[2*c +: 2]     = len;
    bus.req_addr[32*c +: 32]  = addr;
    bus.req_wdata[32*c +: 32] = wd;
    bus.req_valid[c]          = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    flush  = 1'b0;
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_len   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.io_buffer_full = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    mem[12'h010] = 8'hA0; mem[12'h020] = 8'hB0; mem[12'h030] = 8'hC0;
    t3_data[0] = 8'hA0; t3_data[1] = 8'hB0; t3_data[2] = 8'hC0;

    step(); step(); rst_in = 1'b0; step();
    $display("reset state");
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_ch",    32'(bus.resp_ch), 0);
    chk("rst_resp_data",  bus.resp_data, 0);
    chk("rst_mem_a",      bus.mem_a, 0);
    chk("rst_mem_dout",   32'(bus.mem_dout), 0);
    chk("rst_mem_wr",     32'(bus.mem_wr), 0);
    chk("rst_busy",       32'(bus.busy), 0);

    // 1: 4-byte read on ch0
    $display("read ch0 4B @0x100");
    set_req(0, 1'b0, 2'b10, 32'h100, 32'h0);
    step(); chk("t1_a0", bus.mem_a, 32'h100); chk("t1_busy", 32'(bus.busy), 1);
    step(); chk("t1_a1", bus.mem_a, 32'h101);
    step(); chk("t1_a2", bus.mem_a, 32'h102);
    step(); chk("t1_a3", bus.mem_a, 32'h103);
    step(); chk("t1_early", 32'(bus.resp_valid), 0);
    step(); chk("t1_resp", 32'(bus.resp_valid), 1);
    chk("t1_ch", 32'(bus.resp_ch), 0);
    chk("t1_data", bus.resp_data, 32'h44332211);
    bus.req_valid[0] = 1'b0;
    step(); chk("t1_pulse", 32'(bus.resp_valid), 0); chk("t1_idle", 32'(bus.busy), 0);

    // 2: 2-byte write on ch1
    $display("write ch1 2B @0x200");
    set_req(1, 1'b1, 2'b01, 32'h200, 32'h0000BEEF);
    step(); chk("t2_a0", bus.mem_a, 32'h200); chk("t2_d0", 32'(bus.mem_dout), 32'hEF);
    chk("t2_wr0", 32'(bus.mem_wr), 1);
    step(); chk("t2_a1", bus.mem_a, 32'h201); chk("t2_d1", 32'(bus.mem_dout), 32'hBE);
    chk("t2_wr1", 32'(bus.mem_wr), 1);
    step(); chk("t2_resp", 32'(bus.resp_valid), 1); chk("t2_ch", 32'(bus.resp_ch), 1);
    chk("t2_data", bus.resp_data, 0); chk("t2_wr_off", 32'(bus.mem_wr), 0);
    bus.req_valid[1] = 1'b0;
    step(); chk("t2_mem", {16'h0, mem[12'h201], mem[12'h200]}, 32'hBEEF);

    // 3: all channels hold 1-byte reads; grants 0,1,2,0 from a fresh pointer
    rst_in = 1'b1; step(); rst_in = 1'b0;
    set_req(0, 1'b0, 2'b00, 32'h10, 32'h0);
    set_req(1, 1'b0, 2'b00, 32'h20, 32'h0);
    set_req(2, 1'b0, 2'b00, 32'h30, 32'h0);
    for (int i = 0; i < 4; i++) begin
      int ec;
      ec = i % 3;
      $display("round-robin transaction %0d expects ch%0d", i, ec);
      step(); chk($sformatf("t3_%0d_a", i), bus.mem_a, 32'(16 * (ec + 1)));
      step();
      step(); chk($sformatf("t3_%0d_resp", i), 32'(bus.resp_valid), 1);
      chk($sformatf("t3_%0d_ch", i), 32'(bus.resp_ch), 32'(ec));
      chk($sformatf("t3_%0d_data", i), bus.resp_data, {24'h0, t3_data[ec]});
      if (i == 3) bus.req_valid = '0;
      step(); chk($sformatf("t3_%0d_idle", i), 32'(bus.busy), 0);
    end

    // 4: I/O write held off by a full buffer for 5 cycles
    $display("io write 0x41 @0x30000 with buffer full");
    set_req(0, 1'b1, 2'b00, 32'h0003_0000, 32'h41);
    bus.io_buffer_full = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step(); chk($sformatf("t4_stall%0d", j), 32'(bus.mem_wr), 0);
      chk($sformatf("t4_a%0d", j), bus.mem_a, 32'h0003_0000);
      if (j == 5) bus.io_buffer_full = 1'b0;
    end
    step(); chk("t4_wr", 32'(bus.mem_wr), 1); chk("t4_dout", 32'(bus.mem_dout), 32'h41);
    step(); chk("t4_resp", 32'(bus.resp_valid), 1); chk("t4_ch", 32'(bus.resp_ch), 0);
    bus.req_valid[0] = 1'b0;
    step(); chk("t4_mem", 32'(mem[12'h000]), 32'h41);

    // 5a: flush on beat 2 of a ch0 read
    $display("flush aborts ch0 read");
    set_req(0, 1'b0, 2'b10, 32'h100, 32'h0);
    step(); step();
    step(); chk("t5a_a2", bus.mem_a, 32'h102);
    flush = 1'b1; bus.req_valid[0] = 1'b0;
    step(); chk("t5a_idle", 32'(bus.busy), 0); chk("t5a_noresp", 32'(bus.resp_valid), 0);
    flush = 1'b0;
    step(); chk("t5a_noresp2", 32'(bus.resp_valid), 0);

    // 5b: flush during a ch1 write does not stop it
    $display("flush during ch1 write");
    set_req(1, 1'b1, 2'b10, 32'h210, 32'hCAFEF00D);
    step(); chk("t5b_d0", 32'(bus.mem_dout), 32'h0D); chk("t5b_wr0", 32'(bus.mem_wr), 1);
    step(); chk("t5b_d1", 32'(bus.mem_dout), 32'hF0); flush = 1'b1;
    step(); chk("t5b_d2", 32'(bus.mem_dout), 32'hFE); chk("t5b_a2", bus.mem_a, 32'h212);
    flush = 1'b0;
    step(); chk("t5b_d3", 32'(bus.mem_dout), 32'hCA);
    step(); chk("t5b_resp", 32'(bus.resp_valid), 1); chk("t5b_ch", 32'(bus.resp_ch), 1);
    bus.req_valid[1] = 1'b0;
    step(); chk("t5b_mem", {mem[12'h213], mem[12'h212], mem[12'h211], mem[12'h210]}, 32'hCAFEF00D);

    // 5c: grant of a masked read suppressed in a flush cycle, granted the next
    $display("flush in idle suppresses masked ch0 read");
    set_req(0, 1'b0, 2'b00, 32'h10, 32'h0);
    flush = 1'b1;
    step(); chk("t5c_suppr", 32'(bus.busy), 0);
    flush = 1'b0;
    step(); chk("t5c_grant", 32'(bus.busy), 1); chk("t5c_a", bus.mem_a, 32'h10);
    step();
    step(); chk("t5c_resp", 32'(bus.resp_valid), 1); chk("t5c_data", bus.resp_data, 32'hA0);
    bus.req_valid[0] = 1'b0;
    step();

    // 5d: unmasked ch2 read survives flush
    $display("flush ignored for unmasked ch2 read");
    set_req(2, 1'b0, 2'b00, 32'h30, 32'h0);
    flush = 1'b1;
    step(); chk("t5d_busy", 32'(bus.busy), 1);
    step(); flush = 1'b0;
    step(); chk("t5d_resp", 32'(bus.resp_valid), 1); chk("t5d_ch", 32'(bus.resp_ch), 2);
    chk("t5d_data", bus.resp_data, 32'hC0);
    bus.req_valid[2] = 1'b0;
    step();

    // 6: rdy_in low for 3 cycles mid-read stretches latency by 3
    $display("freeze 3 cycles during ch0 read");
    set_req(0, 1'b0, 2'b10, 32'h100, 32'h0);
    step(); chk("t6_a0", bus.mem_a, 32'h100);
    step(); chk("t6_a1", bus.mem_a, 32'h101); rdy_in = 1'b0;
    step(); chk("t6_frz1", bus.mem_a, 32'h101); chk("t6_frz_wr", 32'(bus.mem_wr), 0);
    step(); chk("t6_frz2", bus.mem_a, 32'h101);
    step(); chk("t6_frz3", bus.mem_a, 32'h101); rdy_in = 1'b1;
    step(); chk("t6_a2", bus.mem_a, 32'h102);
    step(); chk("t6_a3", bus.mem_a, 32'h103);
    step(); chk("t6_early", 32'(bus.resp_valid), 0);
    step(); chk("t6_resp", 32'(bus.resp_valid), 1); chk("t6_data", bus.resp_data, 32'h44332211);
    bus.req_valid[0] = 1'b0;
    step();

    // 6b: write strobe drops in the same cycle rdy_in drops
    $display("freeze during ch1 write beat");
    set_req(1, 1'b1, 2'b00, 32'h220, 32'h5A);
    step(); chk("t6b_wr", 32'(bus.mem_wr), 1);
    rdy_in = 1'b0; #1; chk("t6b_gated", 32'(bus.mem_wr), 0);
    step(); chk("t6b_gated2", 32'(bus.mem_wr), 0); chk("t6b_a", bus.mem_a, 32'h220);
    rdy_in = 1'b1; #1; chk("t6b_resume", 32'(bus.mem_wr), 1);
    step(); chk("t6b_resp", 32'(bus.resp_valid), 1); chk("t6b_ch", 32'(bus.resp_ch), 1);
    bus.req_valid[1] = 1'b0;
    step(); chk("t6b_mem", 32'(mem[12'h220]), 32'h5A);

    // 7: reset mid-write abandons the transaction
    $display("reset during ch0 write");
    set_req(0, 1'b1, 2'b10, 32'h240, 32'h01020304);
    step(); chk("t7_wr", 32'(bus.mem_wr), 1);
    step(); rst_in = 1'b1;
    step(); chk("t7_wr_off", 32'(bus.mem_wr), 0); chk("t7_busy", 32'(bus.busy), 0);
    chk("t7_a", bus.mem_a, 0);
    rst_in = 1'b0; bus.req_valid = '0;
    step(); chk("t7_noresp", 32'(bus.resp_valid), 0);
    chk("t7_mem", 32'(mem[12'h242]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
